// File: rtl/rank_filter_pkg.sv
// Shared types and helpers for the rank filter: FSM state encoding and the
// counter/rank width function.
package rank_filter_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, SORT, DONE} state_t;

    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rank_filter_if.sv
// Sample/result handshake bundle of the rank filter; the driver of frames
// uses master, the filter uses slave.
interface rank_filter_if #(
    parameter int WIDTH = 8,
    parameter int N     = 9
) ();
    localparam int RW = rank_filter_pkg::cnt_w(N);

    logic             DSI;
    logic [WIDTH-1:0] DI;
    logic [RW-1:0]    RANK;
    logic [WIDTH-1:0] DO;
    logic             DSO;
    logic             BUSY;

    modport master (output DSI, DI, RANK, input DO, DSO, BUSY);
    modport slave  (input DSI, DI, RANK, output DO, DSO, BUSY);
endinterface

// File: rtl/rank_filter_cmp_swap.sv
// Unsigned compare-exchange cell: HI takes the larger operand, LO the smaller.
module cmp_swap #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);
    logic a_ge_b;

    assign a_ge_b = (A >= B);
    assign HI     = a_ge_b ? A : B;
    assign LO     = a_ge_b ? B : A;
endmodule

// File: rtl/rank_filter.sv
// Windowed rank-order filter: loads N samples, sorts them descending with an
// odd-even transposition network, and reports the sample at the latched rank.
module rank_filter
    import rank_filter_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int N     = 9
) (
    input  logic          CLK,
    input  logic          RST,
    rank_filter_if.slave  bus
);
    localparam int RW = cnt_w(N);
    localparam logic [RW-1:0] LAST = RW'(N - 1);
    localparam logic [RW-1:0] NCYC = RW'(N);
    localparam logic [RW-1:0] ONE  = RW'(1);

    if (N < 3 || N > 15 || (N % 2) == 0 || WIDTH < 1 || WIDTH > 16) begin : g_bad_param
        $fatal(1, "rank_filter: illegal WIDTH/N");
    end

    state_t           state;
    logic [WIDTH-1:0] samples  [N];
    logic [WIDTH-1:0] even_out [N];
    logic [WIDTH-1:0] odd_out  [N];
    logic [RW-1:0]    cnt;
    logic [RW-1:0]    scnt;
    logic [RW-1:0]    rank_lat;
    logic [WIDTH-1:0] dout;
    logic             dso;
    logic             busy;

    function automatic logic [RW-1:0] clamp_rank(input logic [RW-1:0] r);
        return (r >= NCYC) ? LAST : r;
    endfunction

    // Even pass pairs (0,1),(2,3)..; odd pass pairs (1,2),(3,4)..; N odd leaves one end untouched.
    for (genvar i = 0; i < N / 2; i++) begin : g_pair
        cmp_swap #(.WIDTH(WIDTH)) u_even (
            .A (samples[2*i]),   .B (samples[2*i+1]),
            .HI(even_out[2*i]),  .LO(even_out[2*i+1])
        );
        cmp_swap #(.WIDTH(WIDTH)) u_odd (
            .A (samples[2*i+1]), .B (samples[2*i+2]),
            .HI(odd_out[2*i+1]), .LO(odd_out[2*i+2])
        );
    end
    assign even_out[N-1] = samples[N-1];
    assign odd_out[0]    = samples[0];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= IDLE;
            cnt      <= '0;
            scnt     <= '0;
            rank_lat <= '0;
            dout     <= '0;
            dso      <= 1'b0;
            busy     <= 1'b0;
            for (int i = 0; i < N; i++) samples[i] <= '0;
        end else begin
            dso <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (bus.DSI) begin
                        samples[0] <= bus.DI;
                        rank_lat   <= clamp_rank(bus.RANK);
                        cnt        <= ONE;
                        state      <= LOAD;
                        busy       <= 1'b1;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                LOAD: begin
                    if (bus.DSI) begin
                        samples[cnt] <= bus.DI;
                        cnt          <= cnt + ONE;
                        if (cnt == LAST) begin
                            scnt  <= '0;
                            state <= SORT;
                        end
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                SORT: begin
                    // N passes guarantee a full sort; the extra cycle registers the result.
                    if (scnt == NCYC) begin
                        dout  <= samples[rank_lat];
                        dso   <= 1'b1;
                        busy  <= 1'b0;
                        state <= DONE;
                    end else begin
                        for (int i = 0; i < N; i++)
                            samples[i] <= scnt[0] ? odd_out[i] : even_out[i];
                        scnt <= scnt + ONE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.DO   = dout;
    assign bus.DSO  = dso;
    assign bus.BUSY = busy;
endmodule

// File: tb/tb_rank_filter.sv
// Directed and randomized checks of rank_filter: a default N=9/WIDTH=8 instance
// and an N=7/WIDTH=12 instance for the regression.
module tb_rank_filter;
    logic clk   = 1'b0;
    logic rst_a = 1'b0;
    logic rst_b = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    rank_filter_if #(.WIDTH(8),  .N(9)) bus_a ();
    rank_filter_if #(.WIDTH(12), .N(7)) bus_b ();

    rank_filter #(.WIDTH(8),  .N(9)) u_a (.CLK(clk), .RST(rst_a), .bus(bus_a));
    rank_filter #(.WIDTH(12), .N(7)) u_b (.CLK(clk), .RST(rst_b), .bus(bus_b));

    // Drives 9 samples; the first is driven now, the rest on following negedges.
    // RANK is scrambled after the first sample to show only the first is latched.
    task automatic load_a(input logic [7:0] v [9], input logic [3:0] rk);
        for (int i = 0; i < 9; i++) begin
            if (i > 0) @(negedge clk);
            bus_a.DSI  = 1'b1;
            bus_a.DI   = v[i];
            bus_a.RANK = (i == 0) ? rk : ~rk;
        end
    endtask

    // Drops DSI and counts cycles from the last capture edge until DSO (bounded).
    task automatic wait_dso_a(output int lat, output logic [7:0] d);
        @(negedge clk);
        bus_a.DSI = 1'b0;
        lat = 0;
        while (bus_a.DSO !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        d = bus_a.DO;
    endtask

    task automatic test_reset();
        #1 rst_a = 1'b1; rst_b = 1'b1;
        #1;
        n_checks++;
        if ({bus_a.DO, bus_a.DSO, bus_a.BUSY} !== 10'd0) begin
            $display("FAIL reset_a: DO=%h DSO=%b BUSY=%b, need all 0", bus_a.DO, bus_a.DSO, bus_a.BUSY);
            n_fail++;
        end
        n_checks++;
        if ({bus_b.DO, bus_b.DSO, bus_b.BUSY} !== 14'd0) begin
            $display("FAIL reset_b: DO=%h DSO=%b BUSY=%b, need all 0", bus_b.DO, bus_b.DSO, bus_b.BUSY);
            n_fail++;
        end
        @(negedge clk);
        rst_a = 1'b0;
        rst_b = 1'b0;
    endtask

    task automatic test_median();
        logic [7:0] v [9];
        int lat;
        logic [7:0] d;
        v = '{8'd9, 8'd1, 8'd8, 8'd2, 8'd7, 8'd3, 8'd6, 8'd4, 8'd5};
        load_a(v, 4'd4);
        wait_dso_a(lat, d);
        n_checks++;
        if (d !== 8'd5) begin $display("FAIL median_do: got %0d want 5", d); n_fail++; end
        n_checks++;
        if (lat != 10) begin $display("FAIL median_latency: got %0d want 10", lat); n_fail++; end
        repeat (3) @(negedge clk);
        n_checks++;
        if (bus_a.DSO !== 1'b0 || bus_a.DO !== 8'd5) begin
            $display("FAIL median_hold: DSO=%b DO=%0d want 0/5", bus_a.DSO, bus_a.DO);
            n_fail++;
        end
    endtask

    task automatic test_max_min();
        logic [7:0] v [9];
        logic [3:0] rks [3];
        logic [7:0] exps [3];
        int lat;
        logic [7:0] d;
        v    = '{8'd9, 8'd1, 8'd8, 8'd2, 8'd7, 8'd3, 8'd6, 8'd4, 8'd5};
        rks  = '{4'd0, 4'd8, 4'd15};
        exps = '{8'd9, 8'd1, 8'd1};
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            load_a(v, rks[k]);
            wait_dso_a(lat, d);
            n_checks++;
            if (d !== exps[k] || lat != 10) begin
                $display("FAIL rank_%0d: DO=%0d lat=%0d want %0d/10", rks[k], d, lat, exps[k]);
                n_fail++;
            end
        end
    endtask

    task automatic test_abort();
        int pulses = 0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            bus_a.DSI  = 1'b1;
            bus_a.DI   = 8'(20 + i);
            bus_a.RANK = 4'd0;
        end
        @(negedge clk);
        bus_a.DSI = 1'b0;
        n_checks++;
        if (bus_a.BUSY !== 1'b1) begin $display("FAIL abort_busy_load: got %b want 1", bus_a.BUSY); n_fail++; end
        @(negedge clk);
        n_checks++;
        if (bus_a.BUSY !== 1'b0) begin $display("FAIL abort_busy_after: got %b want 0", bus_a.BUSY); n_fail++; end
        for (int i = 0; i < 20; i++) begin
            if (bus_a.DSO === 1'b1) pulses++;
            @(negedge clk);
        end
        n_checks++;
        if (pulses != 0) begin $display("FAIL abort_dso: got %0d pulses want 0", pulses); n_fail++; end
        n_checks++;
        if (bus_a.DO !== 8'd1) begin $display("FAIL abort_do_hold: got %0d want 1", bus_a.DO); n_fail++; end
    endtask

    task automatic test_reset_mid_sort();
        logic [7:0] v [9];
        int pulses = 0;
        int lat;
        logic [7:0] d;
        v = '{8'd9, 8'd1, 8'd8, 8'd2, 8'd7, 8'd3, 8'd6, 8'd4, 8'd5};
        load_a(v, 4'd0);
        @(negedge clk);
        bus_a.DSI = 1'b0;
        repeat (3) @(negedge clk);
        rst_a = 1'b1;
        #1;
        n_checks++;
        if ({bus_a.DO, bus_a.DSO, bus_a.BUSY} !== 10'd0) begin
            $display("FAIL rst_sort_clear: DO=%0d DSO=%b BUSY=%b want 0", bus_a.DO, bus_a.DSO, bus_a.BUSY);
            n_fail++;
        end
        @(negedge clk);
        rst_a = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus_a.DSO === 1'b1) pulses++;
            @(negedge clk);
        end
        n_checks++;
        if (pulses != 0 || bus_a.DO !== 8'd0) begin
            $display("FAIL rst_sort_no_dso: pulses=%0d DO=%0d want 0/0", pulses, bus_a.DO);
            n_fail++;
        end
        load_a(v, 4'd4);
        wait_dso_a(lat, d);
        n_checks++;
        if (d !== 8'd5 || lat != 10) begin
            $display("FAIL rst_sort_recover: DO=%0d lat=%0d want 5/10", d, lat);
            n_fail++;
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] v1 [9];
        logic [7:0] v2 [9];
        int lat;
        logic [7:0] d;
        v1 = '{8'd9, 8'd1, 8'd8, 8'd2, 8'd7, 8'd3, 8'd6, 8'd4, 8'd5};
        v2 = '{8'd3, 8'd3, 8'd7, 8'd1, 8'd9, 8'd0, 8'd2, 8'd8, 8'd5};
        @(negedge clk);
        load_a(v1, 4'd4);
        wait_dso_a(lat, d);
        n_checks++;
        if (d !== 8'd5 || lat != 10) begin
            $display("FAIL b2b_first: DO=%0d lat=%0d want 5/10", d, lat);
            n_fail++;
        end
        load_a(v2, 4'd4);
        wait_dso_a(lat, d);
        n_checks++;
        if (d !== 8'd3 || lat != 10) begin
            $display("FAIL b2b_second: DO=%0d lat=%0d want 3/10", d, lat);
            n_fail++;
        end
    endtask

    task automatic test_random();
        logic [11:0] v [7];
        logic [11:0] s [7];
        logic [11:0] t;
        logic [2:0]  rk;
        logic [11:0] exp_do;
        int lat;
        int bad = 0;
        @(negedge clk);
        for (int f = 0; f <= 1000; f++) begin
            for (int i = 0; i < 7; i++) v[i] = (f == 1000) ? 12'hABC : 12'($urandom_range(0, 4095));
            rk = 3'($urandom_range(0, 7));
            s = v;
            for (int i = 0; i < 7; i++)
                for (int j = 0; j < 6 - i; j++)
                    if (s[j] < s[j+1]) begin t = s[j]; s[j] = s[j+1]; s[j+1] = t; end
            exp_do = s[(rk > 3'd6) ? 6 : int'(rk)];
            for (int i = 0; i < 7; i++) begin
                if (i > 0) @(negedge clk);
                bus_b.DSI  = 1'b1;
                bus_b.DI   = v[i];
                bus_b.RANK = rk;
            end
            @(negedge clk);
            bus_b.DSI = 1'b0;
            lat = 0;
            while (bus_b.DSO !== 1'b1 && lat < 40) begin
                @(negedge clk);
                lat++;
            end
            n_checks++;
            if (bus_b.DO !== exp_do || lat != 8) begin
                n_fail++;
                if (bad < 10)
                    $display("FAIL random_frame_%0d: DO=%h lat=%0d want %h/8 (rank %0d)", f, bus_b.DO, lat, exp_do, rk);
                bad++;
            end
        end
    endtask

    initial begin
        bus_a.DSI = 1'b0; bus_a.DI = '0; bus_a.RANK = '0;
        bus_b.DSI = 1'b0; bus_b.DI = '0; bus_b.RANK = '0;
        test_reset();
        test_median();
        test_max_min();
        test_abort();
        test_reset_mid_sort();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
